// File: rtl/pc_gen_ras.sv
// rtl/pc_gen_ras.sv - Registered fetch next-PC generator with circular return-address stack.
// Optional performance counters are built when PCGEN_PERF_CNT_EN is defined.
module pc_gen_ras #(
    parameter int              PC_W       = 30,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              RAS_DEPTH  = 8,
    parameter bit              IMM_SIGNED = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_redirect_valid,
    input  logic [PC_W-1:0] i_redirect_pc,
    input  logic            i_valid_in,
    input  logic [3:0]      i_op,
    input  logic            i_zero,
    input  logic            i_zgez,
    input  logic            i_zgtz,
    input  logic [15:0]     i_imm,
    input  logic [25:0]     i_target,
    input  logic [PC_W-1:0] i_jr_addr,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_next_pc,
    output logic            o_taken,
    output logic [PC_W-1:0] o_ras_top,
    output logic            o_ras_empty,
    output logic            o_ras_mispredict,
    output logic [31:0]     o_taken_cnt,
    output logic [31:0]     o_ras_miss_cnt
);

    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]   CNT_FULL = CW'(RAS_DEPTH);
    localparam logic [PC_W-1:0] PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_J    = 4'd1;
    localparam logic [3:0] OP_JAL  = 4'd2;
    localparam logic [3:0] OP_JALR = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_BNE  = 4'd5;
    localparam logic [3:0] OP_BGEZ = 4'd6;
    localparam logic [3:0] OP_BLTZ = 4'd7;
    localparam logic [3:0] OP_BGTZ = 4'd8;
    localparam logic [3:0] OP_BLEZ = 4'd9;

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_ras [RAS_DEPTH];
    logic [AW-1:0]   r_wp;
    logic [CW-1:0]   r_cnt;
    logic            r_mispredict;

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_imm_ext;
    logic [PC_W-1:0] w_bt;
    logic [PC_W-1:0] w_jt;
    logic [PC_W-1:0] w_next_pc;
    logic [PC_W-1:0] w_top_entry;
    logic [AW-1:0]   w_wp_dec;
    logic            w_br_cond;
    logic            w_is_branch;
    logic            w_qual;
    logic            w_push;
    logic            w_pop;
    logic            w_mis_next;
    logic            w_taken;

    // The decoded instruction sits at pc-1, so branch offsets are relative to it.
    assign w_pc_inc  = r_pc + PC_ONE;
    assign w_imm_ext = IMM_SIGNED ? {{(PC_W-16){i_imm[15]}}, i_imm}
                                  : {{(PC_W-16){1'b0}}, i_imm};
    assign w_bt      = r_pc - PC_ONE + w_imm_ext;
    assign w_jt      = {r_pc[PC_W-1:26], i_target};

    always_comb begin
        w_br_cond   = 1'b0;
        w_is_branch = 1'b1;
        case (i_op)
            OP_BEQ:  w_br_cond = i_zero;
            OP_BNE:  w_br_cond = ~i_zero;
            OP_BGEZ: w_br_cond = i_zgez;
            OP_BLTZ: w_br_cond = ~i_zgez;
            OP_BGTZ: w_br_cond = i_zgtz;
            OP_BLEZ: w_br_cond = ~i_zgtz;
            default: w_is_branch = 1'b0;
        endcase
    end

    always_comb begin
        w_next_pc = w_pc_inc;
        if (i_redirect_valid)
            w_next_pc = i_redirect_pc;
        else if (i_stall)
            w_next_pc = r_pc;
        else if (i_valid_in) begin
            if (i_op == OP_JALR)
                w_next_pc = i_jr_addr;
            else if (i_op == OP_JAL || i_op == OP_J)
                w_next_pc = w_jt;
            else if (w_is_branch && w_br_cond)
                w_next_pc = w_bt;
        end
    end

    assign w_taken = (w_next_pc != w_pc_inc) && (w_next_pc != r_pc);

    assign w_qual      = i_valid_in & ~i_stall & ~i_redirect_valid;
    assign w_push      = w_qual && (i_op == OP_JAL);
    assign w_pop       = w_qual && (i_op == OP_JALR);
    assign w_wp_dec    = r_wp - 1'b1;
    assign w_top_entry = r_ras[w_wp_dec];
    // An empty stack has no prediction to offer, so every JALR then counts as a miss.
    assign w_mis_next  = w_pop && ((r_cnt == '0) || (w_top_entry != i_jr_addr));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc         <= RESET_PC;
            r_wp         <= '0;
            r_cnt        <= '0;
            r_mispredict <= 1'b0;
        end else begin
            r_pc         <= w_next_pc;
            r_mispredict <= w_mis_next;
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
                if (r_cnt != CNT_FULL)
                    r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && r_cnt != '0) begin
                r_wp  <= w_wp_dec;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Stack storage needs no reset: entries are only visible while r_cnt covers them.
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_ras[r_wp] <= r_pc;
    end

`ifdef PCGEN_PERF_CNT_EN
    logic [31:0] r_taken_cnt;
    logic [31:0] r_ras_miss_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_taken_cnt    <= '0;
            r_ras_miss_cnt <= '0;
        end else begin
            if (w_qual && w_taken)
                r_taken_cnt <= r_taken_cnt + 32'd1;
            if (w_mis_next)
                r_ras_miss_cnt <= r_ras_miss_cnt + 32'd1;
        end
    end

    assign o_taken_cnt    = r_taken_cnt;
    assign o_ras_miss_cnt = r_ras_miss_cnt;
`else
    assign o_taken_cnt    = 32'd0;
    assign o_ras_miss_cnt = 32'd0;
`endif

    assign o_pc             = r_pc;
    assign o_next_pc        = w_next_pc;
    assign o_taken          = w_taken;
    assign o_ras_top        = (r_cnt != '0) ? w_top_entry : '0;
    assign o_ras_empty      = (r_cnt == '0);
    assign o_ras_mispredict = r_mispredict;

endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
- Registered next-PC generator for the pipeline fetch stage. Holds the word-addressed fetch PC and applies decoded control-flow ops each cycle: sequential, J, JAL, JALR and the six conditional branches.
- Adds stall, external redirect, sign-extended branch offsets, parametrised PC width, and a circular return-address stack (RAS) that predicts JALR targets and flags mispredictions.
- Sits between the decode-stage control signals and the instruction-memory address port.

Parameters:
- PC_W, 30, word-address width; legal range 27..32.
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 8, RAS entries; power of two, 2..64.
- IMM_SIGNED, 1, 1 = sign-extend imm, 0 = zero-extend.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and RAS.
- redirect_valid  in  1  exception/flush redirect.
- redirect_pc  in  PC_W  redirect destination.
- valid_in  in  1  op/operand fields valid this cycle.
- op  in  4  0 SEQ, 1 J, 2 JAL, 3 JALR, 4 BEQ, 5 BNE, 6 BGEZ, 7 BLTZ, 8 BGTZ, 9 BLEZ; 10-15 treated as SEQ.
- zero  in  1  ALU equality flag.
- zgez  in  1  rs >= 0.
- zgtz  in  1  rs > 0.
- imm  in  16  branch offset, in words.
- target  in  26  jump target field.
- jr_addr  in  PC_W  authoritative JALR target.
- pc  out  PC_W  registered fetch PC.
- next_pc  out  PC_W  combinational value loaded at the next edge.
- taken  out  1  combinational; 1 when next_pc is not pc+1 or pc.
- ras_top  out  PC_W  top RAS entry; 0 when empty.
- ras_empty  out  1  RAS count == 0.
- ras_mispredict  out  1  registered one-cycle pulse.
- taken_cnt  out  32  performance counter (see Optional Feature).
- ras_miss_cnt  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset, asynchronous on rst_n low at any time, including mid-operation:
  - pc = RESET_PC.
  - RAS count = 0, write pointer = 0, ras_empty = 1, ras_top = 0.
  - ras_mispredict = 0; counters = 0.
- Branch target: bt = pc - 1 + ext(imm), ext per IMM_SIGNED, modulo 2^PC_W (wrap, no overflow flag). The instruction in decode sits at pc-1.
- Jump target: jt = {pc[PC_W-1:26], target}.
- next_pc priority:
  1. redirect_valid -> redirect_pc (overrides stall; RAS untouched).
  2. stall -> pc (hold).
  3. valid_in = 0 -> pc+1.
  4. JALR -> jr_addr.
  5. JAL or J -> jt.
  6. BEQ taken iff zero; BNE iff !zero; BGEZ iff zgez; BLTZ iff !zgez; BGTZ iff zgtz; BLEZ iff !zgtz. Taken -> bt, else pc+1.
  7. SEQ / other -> pc+1.
- pc <= next_pc every edge. Latency is 1 cycle from op to pc update.
- RAS updates only when valid_in=1, stall=0, redirect_valid=0.
  - JAL push: entry[wp] = pc (return address), wp++ mod RAS_DEPTH, count = min(count+1, RAS_DEPTH).
  - Full push: overwrites the oldest entry; count stays RAS_DEPTH.
  - JALR pop when count > 0: wp--, count--; ras_mispredict <= (entry[wp-1] != jr_addr).
  - JALR pop when empty: no state change; ras_mispredict <= 1.
  - ras_top = entry[wp-1] when count > 0.
- ras_mispredict is 0 in every cycle without a qualifying JALR.
- JALR target is always jr_addr; the RAS is advisory only.

Optional Feature:
- Macro PCGEN_PERF_CNT_EN.
- Defined:
  - taken_cnt increments on each qualifying cycle (valid_in=1, stall=0, redirect_valid=0) with taken=1.
  - ras_miss_cnt increments on each ras_mispredict pulse.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: both ports are tied to 0; no counter flops are synthesised.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with pc=0x55 -> pc=0 immediately, ras_empty=1. Release with valid_in=0 -> pc reads 1, 2, 3 on successive edges.
- BEQ at pc=0x10, imm=0xFFFC, zero=1 -> pc=0x0B, taken=1. Same with zero=0 -> pc=0x11, taken=0. IMM_SIGNED=0, imm=0x0004, zero=1 -> pc=0x13.
- JAL at pc=0x20, target=0x100 -> pc=0x100, ras_top=0x20. Then JALR with jr_addr=0x20 -> pc=0x20, ras_mispredict=0, ras_empty=1. JALR with jr_addr=0x24 instead -> ras_mispredict=1 for one cycle.
- RAS_DEPTH=8: nine JALs from pc=0x40, 0x50, ... 0xC0 -> count 8, 0x40 lost. Eight JALRs with matching jr_addr -> no mispredict. Ninth JALR -> ras_mispredict=1, ras_empty stays 1.
- stall=1 with valid BNE, zero=0 -> pc holds, RAS unchanged. redirect_valid=1, redirect_pc=0x3000 during stall -> pc=0x3000 next edge.
- With PCGEN_PERF_CNT_EN: 5 taken branches plus 2 mispredicting JALRs -> taken_cnt=7, ras_miss_cnt=2. Without the macro -> both read 0.
